// File: rtl/eth_idma_desc_queue.sv
// Descriptor FIFO feeding the iDMA backend request port; tracks outstanding
// transfers, counts completions/errors and raises a level completion interrupt.
module eth_idma_desc_queue #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned TFLenWidth     = 32,
  parameter int unsigned DescDepth      = 4,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned CntWidth       = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  push_i,
  input  logic [AddrWidth-1:0]                  push_src_i,
  input  logic [AddrWidth-1:0]                  push_dst_i,
  input  logic [TFLenWidth-1:0]                 push_len_i,
  input  logic                                  push_tx_i,
  input  logic                                  flush_i,
  input  logic                                  irq_clr_i,
  output logic [AddrWidth-1:0]                  req_src_o,
  output logic [AddrWidth-1:0]                  req_dst_o,
  output logic [TFLenWidth-1:0]                 req_len_o,
  output logic                                  req_tx_o,
  output logic                                  req_valid_o,
  input  logic                                  req_ready_i,
  input  logic                                  rsp_valid_i,
  input  logic                                  rsp_error_i,
  output logic                                  rsp_ready_o,
  output logic [$clog2(DescDepth):0]            fill_o,
  output logic [$clog2(MaxOutstanding):0]       outstanding_o,
  output logic [CntWidth-1:0]                   done_cnt_o,
  output logic [CntWidth-1:0]                   err_cnt_o,
  output logic                                  overflow_o,
  output logic                                  busy_o,
  output logic                                  irq_o
);

  localparam int unsigned PtrW  = $clog2(DescDepth);
  localparam int unsigned FillW = $clog2(DescDepth) + 1;
  localparam int unsigned OutW  = $clog2(MaxOutstanding) + 1;

  typedef struct packed {
    logic [AddrWidth-1:0]  src;
    logic [AddrWidth-1:0]  dst;
    logic [TFLenWidth-1:0] len;
    logic                  tx;
  } desc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  desc_t               mem_q [DescDepth];
  desc_t               head_q, head_d;
  desc_t               push_desc;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0]    fill_q, fill_d;
  logic [OutW-1:0]     out_q, out_d;
  logic [CntWidth-1:0] done_q, done_d, err_q, err_d;
  logic                req_valid_q, req_valid_d;
  logic                ovf_q, ovf_d, irq_q, irq_d, busy_q, busy_d;
  logic                rsp_ready_q;
  logic                pop, rsp_acc, flush_now, drop_silent, push_ok;

  assign push_desc   = '{src: push_src_i, dst: push_dst_i, len: push_len_i, tx: push_tx_i};
  assign pop         = req_valid_q && req_ready_i;
  assign rsp_acc     = rsp_valid_i && rsp_ready_q && (out_q != '0);
  assign flush_now   = (state_q == ST_BUSY) && flush_i;
  // Pushes racing a flush, or arriving while flushing, vanish without flagging overflow.
  assign drop_silent = flush_now || (state_q == ST_FLUSH);
  assign push_ok     = push_i && !drop_silent && (fill_q < FillW'(DescDepth)) &&
                       (push_len_i != '0);

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d    = rd_ptr_q + PtrW'(pop);
    fill_d      = fill_q + FillW'(push_ok) - FillW'(pop);
    out_d       = out_q + OutW'(pop) - OutW'(rsp_acc);
    done_d      = done_q + CntWidth'(rsp_acc);
    err_d       = err_q;
    ovf_d       = ovf_q | (push_i && !drop_silent && !push_ok);
    irq_d       = irq_q;
    head_d      = head_q;
    req_valid_d = 1'b0;
    busy_d      = 1'b0;

    if (flush_now) begin
      fill_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    if (rsp_acc && rsp_error_i && (err_q != '1)) err_d = err_q + CntWidth'(1);

    if (rsp_acc)        irq_d = 1'b1;
    else if (irq_clr_i) irq_d = 1'b0;

    case (state_q)
      ST_IDLE:  if (fill_d != '0) state_d = ST_BUSY;
      ST_BUSY: begin
        if (flush_now)                           state_d = ST_FLUSH;
        else if ((fill_d == '0) && (out_d == '0)) state_d = ST_IDLE;
      end
      ST_FLUSH: if (out_d == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Bypass a write landing on the next head slot so req_* updates the cycle after push.
    if (push_ok && (wr_ptr_q == rd_ptr_d)) head_d = push_desc;
    else                                   head_d = mem_q[rd_ptr_d];

    req_valid_d = (state_d == ST_BUSY) && (fill_d != '0) && (out_d < OutW'(MaxOutstanding));
    busy_d      = (state_d != ST_IDLE);
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      for (int unsigned i = 0; i < DescDepth; i++) mem_q[i] <= '0;
      head_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      out_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      req_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
      rsp_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (push_ok) mem_q[wr_ptr_q] <= push_desc;
      head_q      <= head_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      out_q       <= out_d;
      done_q      <= done_d;
      err_q       <= err_d;
      req_valid_q <= req_valid_d;
      ovf_q       <= ovf_d;
      irq_q       <= irq_d;
      busy_q      <= busy_d;
      rsp_ready_q <= 1'b1;
    end
  end

  assign req_src_o     = head_q.src;
  assign req_dst_o     = head_q.dst;
  assign req_len_o     = head_q.len;
  assign req_tx_o      = head_q.tx;
  assign req_valid_o   = req_valid_q;
  assign rsp_ready_o   = rsp_ready_q;
  assign fill_o        = fill_q;
  assign outstanding_o = out_q;
  assign done_cnt_o    = done_q;
  assign err_cnt_o     = err_q;
  assign overflow_o    = ovf_q;
  assign busy_o        = busy_q;
  assign irq_o         = irq_q;

endmodule
